mandelbrot_pixel_packer: RTL and testbench
==========================================

// Module: mandelbrot_pixel_packer
// PURPOSE
//  Downstream stage of the Mandelbrot iteration engine. Paces the engine one pixel at a
//  time via its run/running handshake and captures each 4-bit iteration code as the
//  pixel completes. Packs two pixels per byte (first pixel in high nibble) into a small
//  FIFO, presented on a valid/ready stream with an end-of-frame marker. Throttles the
//  engine so that no pixel is ever lost.
// PARAMETERS
//  WIDTH       320  pixels per line (must match engine)
//  HEIGHT      240  lines per frame (must match engine)
//  FIFO_DEPTH  4    output FIFO entries (bytes + last flag), power of two, >=2
// PORTS
//  clk            in   1  clock
//  reset          in   1  synchronous, active-high reset
//  start_frame    in   1  pulse: begin a frame (ignored unless IDLE)
//  busy           out  1  high while a frame is in progress (state != IDLE)
//  frame_err      out  1  sticky: engine finished flag disagreed with pixel count
//  eng_run        out  1  to engine run; one-cycle start pulse
//  eng_running    in   1  from engine running
//  eng_ctr        in   4  from engine ctr_out; valid when eng_running falls
//  eng_finished   in   1  from engine finished
//  m_data         out  8  packed byte {pixel n, pixel n+1}
//  m_valid        out  1  FIFO not empty
//  m_ready        in   1  consumer accepts when m_valid & m_ready
//  m_last         out  1  marks final byte of the frame
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, eng_run=0, m_valid=0, m_last=0, m_data=0, frame_err=0,
//    FIFO emptied, pixel counter=0, nibble holder=0. Reset mid-frame abandons the frame;
//    engine is reset by its own port.
//  - States: IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> ISSUE|IDLE.
//    IDLE: start_frame=1 -> ISSUE; clears pixel counter, half flag and frame_err.
//    ISSUE: if fifo_count < FIFO_DEPTH, drive eng_run=1 for exactly one cycle -> WAIT_START;
//      else hold eng_run=0 and stay (backpressure; engine idles stopped).
//    WAIT_START: wait for eng_running=1 -> WAIT_DONE.
//    WAIT_DONE: on eng_running=0, capture eng_ctr the same cycle (engine updates ctr_out and
//      running on the same edge). If half=0: hold nibble, half<=1. If half=1: push
//      {held, eng_ctr}, half<=0. Last pixel (count == WIDTH*HEIGHT-1): push
//      {held, eng_ctr} or, if half=0 (odd pixel total), {eng_ctr, 4'h0}, with last=1;
//      -> IDLE. Else count+1 -> ISSUE.
//  - Space check in ISSUE guarantees room for the one push a pixel can cause; a push
//    never meets a full FIFO.
//  - Cross-check at last pixel: eng_finished must be 1 the cycle after capture; on any
//    capture with eng_finished=1 before the last pixel, or 0 after it, frame_err<=1.
//  - FIFO: first-word-fall-through; m_data/m_last reflect head entry; push and pop in the
//    same cycle leave count unchanged. Push-to-m_valid latency one cycle (registered).
//  - Pixel counter width $clog2(WIDTH*HEIGHT); no wrap within a frame.
//  - start_frame while busy ignored. m_ready while !m_valid has no effect.
//  - Pixel rate bounded by engine; packer adds 2 cycles/pixel (ISSUE, WAIT_START).
// TESTING
//  1 Reset, WIDTH=4,HEIGHT=2, engine model returns ctr 1..8, m_ready=1 -> bytes 0x12,
//    0x34,0x56,0x78; m_last only on 0x78; busy falls after; frame_err=0.
//  2 Same, m_ready=0 throughout -> exactly FIFO_DEPTH=4 bytes held, eng_run stays 0 after
//    pixel 8; raise m_ready -> bytes drain in order, no loss or duplication.
//  3 WIDTH=3,HEIGHT=1, ctrs 0xA,0xB,0xC -> bytes 0xAB, 0xC0 (m_last=1 on 0xC0).
//  4 Model asserts eng_finished after pixel 5 of 8 -> frame_err=1 and sticky until next
//    start_frame.
//  5 Assert reset during WAIT_DONE with 3 bytes queued -> next cycle m_valid=0, busy=0,
//    eng_run=0; new start_frame runs a clean frame matching scenario 1.
//  6 start_frame pulsed while busy and m_ready toggled randomly -> single frame, byte
//    order intact, eng_run never high two consecutive cycles.

Source files
------------

// File: rtl/mandelbrot_pixel_packer_if.sv
// rtl/mandelbrot_pixel_packer_if.sv - packed-pixel byte stream between packer and consumer
interface mandelbrot_pixel_packer_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/mandelbrot_pixel_packer.sv
// rtl/mandelbrot_pixel_packer.sv - paces the Mandelbrot engine pixel by pixel and packs
// two 4-bit iteration codes per byte into a small first-word-fall-through FIFO.
module mandelbrot_pixel_packer #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start_frame,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_eng_run,
    input  logic       i_eng_running,
    input  logic [3:0] i_eng_ctr,
    input  logic       i_eng_finished,
    mandelbrot_pixel_packer_if.master m_if
);
    localparam int NPIX = WIDTH * HEIGHT;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] LAST_IDX   = CW'(NPIX - 1);
    localparam logic [AW:0]   FIFO_LIMIT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_pix_cnt;
    logic            r_half;
    logic [3:0]      r_held;
    logic            r_fin_chk;
    logic            r_frame_err;
    logic            r_eng_run;

    logic [8:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    logic            w_capture;
    logic            w_last_pix;
    logic            w_push;
    logic            w_pop;
    logic [8:0]      w_push_entry;

    // Engine drops running and presents ctr on the same edge, so capture is combinational.
    assign w_capture    = (r_state == S_WAIT_DONE) && !i_eng_running;
    assign w_last_pix   = (r_pix_cnt == LAST_IDX);
    assign w_push       = w_capture && (r_half || w_last_pix);
    assign w_push_entry = r_half ? {w_last_pix, r_held, i_eng_ctr}
                                 : {w_last_pix, i_eng_ctr, 4'h0};
    assign w_pop        = (r_count != '0) && m_if.m_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pix_cnt   <= '0;
            r_half      <= 1'b0;
            r_held      <= 4'h0;
            r_fin_chk   <= 1'b0;
            r_frame_err <= 1'b0;
            r_eng_run   <= 1'b0;
        end else begin
            r_eng_run <= 1'b0;
            r_fin_chk <= 1'b0;
            if (r_fin_chk && !i_eng_finished) begin
                r_frame_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start_frame) begin
                        r_state     <= S_ISSUE;
                        r_pix_cnt   <= '0;
                        r_half      <= 1'b0;
                        r_frame_err <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    // One free slot covers the single push any pixel can cause.
                    if (r_count < FIFO_LIMIT) begin
                        r_eng_run <= 1'b1;
                        r_state   <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (i_eng_running) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_capture) begin
                        if (w_last_pix) begin
                            r_half    <= 1'b0;
                            r_fin_chk <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            if (i_eng_finished) begin
                                r_frame_err <= 1'b1;
                            end
                            if (!r_half) begin
                                r_held <= i_eng_ctr;
                            end
                            r_half    <= ~r_half;
                            r_pix_cnt <= r_pix_cnt + CW'(1);
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_push_entry;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_err  = r_frame_err;
    assign o_eng_run    = r_eng_run;
    assign m_if.m_valid = (r_count != '0);
    assign m_if.m_data  = r_mem[r_rd_ptr][7:0];
    assign m_if.m_last  = (r_count != '0) && r_mem[r_rd_ptr][8];
endmodule

// File: tb/tb_mandelbrot_pixel_packer.sv
// tb/tb_mandelbrot_pixel_packer.sv - bench for mandelbrot_pixel_packer with an engine model
module tb_mandelbrot_pixel_packer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       start [2];
    logic       busy [2];
    logic       ferr [2];
    logic       run [2];
    logic       running [2];
    logic       fin [2];
    logic [3:0] ctr [2];

    mandelbrot_pixel_packer_if if0();
    mandelbrot_pixel_packer_if if1();

    mandelbrot_pixel_packer #(.WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .reset(rst[0]), .i_start_frame(start[0]), .o_busy(busy[0]),
        .o_frame_err(ferr[0]), .o_eng_run(run[0]), .i_eng_running(running[0]),
        .i_eng_ctr(ctr[0]), .i_eng_finished(fin[0]), .m_if(if0)
    );

    mandelbrot_pixel_packer #(.WIDTH(3), .HEIGHT(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset(rst[1]), .i_start_frame(start[1]), .o_busy(busy[1]),
        .o_frame_err(ferr[1]), .o_eng_run(run[1]), .i_eng_running(running[1]),
        .i_eng_ctr(ctr[1]), .i_eng_finished(fin[1]), .m_if(if1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int e_st [2], e_cnt [2], e_idx [2], fin_after [2], runs [2], viol [2];
    int e_rmin [2], e_rmax [2];
    int npix [2] = '{8, 3};
    logic       prev_run [2];
    logic [3:0] seq [2][16];
    logic [8:0] cap [2][$];
    logic [8:0] exp_q [2][$];

    // Engine model: start latency 0..2 cycles, run length e_rmin..e_rmax cycles.
    task automatic engine_step(input int k);
        if (rst[k]) begin
            running[k] = 1'b0;
            fin[k]     = 1'b0;
            e_st[k]    = 0;
        end else begin
            case (e_st[k])
                0: if (run[k]) begin
                    e_cnt[k] = $urandom_range(0, 2);
                    e_st[k]  = 1;
                end
                1: if (e_cnt[k] == 0) begin
                    running[k] = 1'b1;
                    e_cnt[k]   = $urandom_range(e_rmin[k], e_rmax[k]);
                    e_st[k]    = 2;
                end else e_cnt[k]--;
                2: if (e_cnt[k] == 0) begin
                    running[k] = 1'b0;
                    ctr[k]     = seq[k][e_idx[k] % 16];
                    e_st[k]    = 3;
                end else e_cnt[k]--;
                default: begin
                    e_idx[k]++;
                    if (e_idx[k] >= fin_after[k]) fin[k] = 1'b1;
                    e_st[k] = 0;
                end
            endcase
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            engine_step(0);
            engine_step(1);
        end
    end

    always @(negedge clk) begin
        if (if0.m_valid === 1'b1 && if0.m_ready === 1'b1) cap[0].push_back({if0.m_last, if0.m_data});
        if (if1.m_valid === 1'b1 && if1.m_ready === 1'b1) cap[1].push_back({if1.m_last, if1.m_data});
        for (int k = 0; k < 2; k++) begin
            if (run[k] === 1'b1) begin
                runs[k]++;
                if (prev_run[k] === 1'b1) viol[k]++;
            end
            prev_run[k] = run[k];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ready(input int k, input logic v);
        if (k == 0) if0.m_ready = v;
        else        if1.m_ready = v;
    endtask

    function automatic logic get_valid(input int k);
        return (k == 0) ? if0.m_valid : if1.m_valid;
    endfunction

    // Reference: pair pixels high-nibble first, pad an odd tail with 0, last flag on final byte.
    task automatic build_expected(input int k);
        exp_q[k].delete();
        for (int i = 0; i < npix[k]; i += 2) begin
            logic [3:0] lo;
            logic       lst;
            lo  = (i + 1 < npix[k]) ? seq[k][i + 1] : 4'h0;
            lst = (i + 2 >= npix[k]);
            exp_q[k].push_back({lst, seq[k][i], lo});
        end
    endtask

    task automatic begin_frame(input int k, input int fa);
        cap[k].delete();
        runs[k]      = 0;
        viol[k]      = 0;
        e_idx[k]     = 0;
        fin[k]       = 1'b0;
        fin_after[k] = fa;
        build_expected(k);
        start[k] = 1'b1;
        tick(1);
        start[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy[k]) begin
                ok = 1'b1;
                return;
            end
            tick(1);
        end
    endtask

    task automatic test_reset;
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        tick(2);
        for (int k = 0; k < 2; k++) begin
            n_checks += 4;
            if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
            if (run[k] !== 1'b0) begin n_fail++; $display("FAIL reset_run[%0d]: got %b want 0", k, run[k]); end
            if (get_valid(k) !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", k, get_valid(k)); end
            if (ferr[k] !== 1'b0) begin n_fail++; $display("FAIL reset_ferr[%0d]: got %b want 0", k, ferr[k]); end
        end
        n_checks += 2;
        if (if0.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", if0.m_data); end
        if (if0.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", if0.m_last); end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick(1);
    endtask

    task automatic test_basic_frame;
        bit ok;
        for (int i = 0; i < 8; i++) seq[0][i] = 4'(i + 1);
        set_ready(0, 1'b1);
        begin_frame(0, 8);
        wait_idle(0, ok);
        tick(4);
        n_checks += 6;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: busy still %b", busy[0]); end
        if (cap[0].size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", cap[0].size()); end
        for (int i = 0; i < cap[0].size() && i < exp_q[0].size(); i++) begin
            n_checks++;
            if (cap[0][i] !== exp_q[0][i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h want %h", i, cap[0][i], exp_q[0][i]); end
        end
        if (exp_q[0].size() == 4 && cap[0].size() == 4 && cap[0][3] !== 9'h178) begin n_fail++; $display("FAIL basic_last: got %h want 178", cap[0][3]); end
        if (ferr[0] !== 1'b0) begin n_fail++; $display("FAIL basic_ferr: got %b want 0", ferr[0]); end
        if (runs[0] != 8) begin n_fail++; $display("FAIL basic_runs: got %0d want 8", runs[0]); end
        if (viol[0] != 0) begin n_fail++; $display("FAIL basic_run_pulse: got %0d double pulses want 0", viol[0]); end
    endtask

    task automatic test_backpressure;
        bit ok;
        set_ready(0, 1'b0);
        begin_frame(0, 8);
        wait_idle(0, ok);
        tick(20);
        n_checks += 5;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: busy still %b", busy[0]); end
        if (cap[0].size() != 0) begin n_fail++; $display("FAIL bp_held: got %0d popped want 0", cap[0].size()); end
        if (if0.m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", if0.m_valid); end
        if (runs[0] != 8) begin n_fail++; $display("FAIL bp_runs: got %0d want 8", runs[0]); end
        if (run[0] !== 1'b0) begin n_fail++; $display("FAIL bp_run_idle: got %b want 0", run[0]); end
        set_ready(0, 1'b1);
        tick(10);
        n_checks += 2;
        if (cap[0].size() != 4) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 4", cap[0].size()); end
        if (if0.m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b want 0", if0.m_valid); end
        for (int i = 0; i < cap[0].size() && i < exp_q[0].size(); i++) begin
            n_checks++;
            if (cap[0][i] !== exp_q[0][i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h want %h", i, cap[0][i], exp_q[0][i]); end
        end
    endtask

    task automatic test_odd_total;
        bit ok;
        seq[1][0] = 4'hA;
        seq[1][1] = 4'hB;
        seq[1][2] = 4'hC;
        set_ready(1, 1'b1);
        begin_frame(1, 3);
        wait_idle(1, ok);
        tick(4);
        n_checks += 3;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL odd_timeout: busy still %b", busy[1]); end
        if (cap[1].size() != 2) begin n_fail++; $display("FAIL odd_count: got %0d want 2", cap[1].size()); end
        if (ferr[1] !== 1'b0) begin n_fail++; $display("FAIL odd_ferr: got %b want 0", ferr[1]); end
        for (int i = 0; i < cap[1].size() && i < exp_q[1].size(); i++) begin
            n_checks++;
            if (cap[1][i] !== exp_q[1][i]) begin n_fail++; $display("FAIL odd_byte%0d: got %h want %h", i, cap[1][i], exp_q[1][i]); end
        end
        if (cap[1].size() == 2) begin
            n_checks++;
            if (cap[1][1] !== 9'h1C0) begin n_fail++; $display("FAIL odd_tail: got %h want 1c0", cap[1][1]); end
        end
    endtask

    task automatic test_frame_err;
        bit ok;
        for (int i = 0; i < 8; i++) seq[0][i] = 4'($urandom);
        set_ready(0, 1'b1);
        begin_frame(0, 5);
        wait_idle(0, ok);
        tick(4);
        n_checks += 3;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL ferr_timeout: busy still %b", busy[0]); end
        if (ferr[0] !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b want 1", ferr[0]); end
        if (cap[0].size() != 4) begin n_fail++; $display("FAIL ferr_count: got %0d want 4", cap[0].size()); end
        tick(20);
        n_checks++;
        if (ferr[0] !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %b want 1", ferr[0]); end
        begin_frame(0, 8);
        n_checks++;
        if (ferr[0] !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b want 0", ferr[0]); end
        wait_idle(0, ok);
        tick(4);
        n_checks++;
        if (ferr[0] !== 1'b0) begin n_fail++; $display("FAIL ferr_clean_frame: got %b want 0", ferr[0]); end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        bit hit;
        for (int i = 0; i < 8; i++) seq[0][i] = 4'(i + 1);
        set_ready(0, 1'b0);
        e_rmin[0] = 6;
        e_rmax[0] = 6;
        begin_frame(0, 8);
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            if (e_idx[0] == 6 && e_st[0] == 2 && e_cnt[0] >= 2) hit = 1'b1;
            else tick(1);
        end
        tick(1);
        n_checks += 2;
        if (hit !== 1'b1) begin n_fail++; $display("FAIL rmid_reach: pixel 7 not reached, got %0d want 1", hit); end
        if (if0.m_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_queued: got %b want 1", if0.m_valid); end
        rst[0] = 1'b1;
        tick(1);
        n_checks += 3;
        if (if0.m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", if0.m_valid); end
        if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy[0]); end
        if (run[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_run: got %b want 0", run[0]); end
        tick(1);
        rst[0] = 1'b0;
        e_rmin[0] = 0;
        e_rmax[0] = 4;
        tick(2);
        set_ready(0, 1'b1);
        begin_frame(0, 8);
        wait_idle(0, ok);
        tick(4);
        n_checks += 3;
        if (ok !== 1'b1) begin n_fail++; $display("FAIL rmid_timeout: busy still %b", busy[0]); end
        if (cap[0].size() != 4) begin n_fail++; $display("FAIL rmid_count: got %0d want 4", cap[0].size()); end
        if (ferr[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_ferr: got %b want 0", ferr[0]); end
        for (int i = 0; i < cap[0].size() && i < exp_q[0].size(); i++) begin
            n_checks++;
            if (cap[0][i] !== exp_q[0][i]) begin n_fail++; $display("FAIL rmid_byte%0d: got %h want %h", i, cap[0][i], exp_q[0][i]); end
        end
    endtask

    task automatic test_back_to_back;
        for (int f = 0; f < 3; f++) begin
            bit done;
            for (int i = 0; i < 8; i++) seq[0][i] = 4'($urandom);
            begin_frame(0, 8);
            done = 1'b0;
            for (int c = 0; c < 3000 && !done; c++) begin
                set_ready(0, 1'($urandom_range(0, 1)));
                start[0] = busy[0] && ($urandom_range(0, 2) == 0);
                tick(1);
                if (!busy[0] && cap[0].size() >= 4) done = 1'b1;
            end
            start[0] = 1'b0;
            set_ready(0, 1'b1);
            tick(6);
            n_checks += 5;
            if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout%0d: got %0d bytes want 4", f, cap[0].size()); end
            if (cap[0].size() != 4) begin n_fail++; $display("FAIL b2b_count%0d: got %0d want 4", f, cap[0].size()); end
            if (runs[0] != 8) begin n_fail++; $display("FAIL b2b_runs%0d: got %0d want 8", f, runs[0]); end
            if (viol[0] != 0) begin n_fail++; $display("FAIL b2b_run_pulse%0d: got %0d want 0", f, viol[0]); end
            if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy%0d: got %b want 0", f, busy[0]); end
            for (int i = 0; i < cap[0].size() && i < exp_q[0].size(); i++) begin
                n_checks++;
                if (cap[0][i] !== exp_q[0][i]) begin n_fail++; $display("FAIL b2b_byte%0d_%0d: got %h want %h", f, i, cap[0][i], exp_q[0][i]); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k]       = 1'b1;
            start[k]     = 1'b0;
            running[k]   = 1'b0;
            fin[k]       = 1'b0;
            ctr[k]       = 4'h0;
            e_st[k]      = 0;
            e_cnt[k]     = 0;
            e_idx[k]     = 0;
            e_rmin[k]    = 0;
            e_rmax[k]    = 4;
            fin_after[k] = npix[k];
            runs[k]      = 0;
            viol[k]      = 0;
            prev_run[k]  = 1'b0;
        end
        if0.m_ready = 1'b0;
        if1.m_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_odd_total();
        test_frame_err();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
